// File: rtl/controller_sseg_scan_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// CTRL bit positions, FSM states and the hex-to-segment table.
package controller_sseg_scan_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_DIGITS   = 3'd2;
    localparam logic [2:0] ADDR_DPMASK   = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_BLANK_ALL = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // Active-high segments, bit0 = a .. bit6 = g
    function automatic logic [6:0] hex_segments(input logic [3:0] value);
        logic [6:0] segs;
        case (value)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h7C;
            4'hC: segs = 7'h39;
            4'hD: segs = 7'h5E;
            4'hE: segs = 7'h79;
            default: segs = 7'h71;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/controller_sseg_scan_if.sv
// Avalon-MM slave bus between the Nios II data master and the scan controller.
interface controller_sseg_scan_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/controller_sseg_hex_decoder.sv
// Combinational hex nibble to seven-segment decode with selectable polarity.
module controller_sseg_hex_decoder
    import controller_sseg_scan_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = ACTIVE_LOW ? ~hex_segments(value) : hex_segments(value);
    end

endmodule

// File: rtl/controller_sseg_scan.sv
// Seven-segment display scanner: Avalon-MM register file, shared prescale/blank
// down-counter, IDLE/ON/BLANK FSM, scan counter and registered read mux.
module controller_sseg_scan
    import controller_sseg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE_W     = 16,
    parameter int BLANK_CYCLES   = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    controller_sseg_scan_if.slave avs,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  scan_of
);

    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int CNT_W   = (PRESCALE_W > BLANK_W) ? PRESCALE_W : BLANK_W;

    logic [1:0]              ctrl;
    logic [PRESCALE_W-1:0]   prescale;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dpmask;
    logic [15:0]             scan_cnt;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              digit_idx;
    logic [31:0]             rd_mux;
    logic [31:0]             readdata_q;
    state_t                  state, next_state;
    logic                    enable, wr_en, status_wr, wrap, lit;
    logic [NUM_DIGITS-1:0]   sel_oh;
    logic [4*NUM_DIGITS-1:0] digits_shifted;
    logic [6:0]              seg_dec;
    logic                    unused_wdata;

    assign enable       = ctrl[CTRL_ENABLE];
    assign wr_en        = avs.chipselect && !avs.write_n;
    assign status_wr    = wr_en && (avs.address == ADDR_STATUS);
    assign unused_wdata = ^avs.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            prescale <= '0;
            digits   <= '0;
            dpmask   <= '0;
        end else if (wr_en) begin
            case (avs.address)
                ADDR_CTRL:     ctrl     <= avs.writedata[1:0];
                ADDR_PRESCALE: prescale <= avs.writedata[PRESCALE_W-1:0];
                ADDR_DIGITS:   digits   <= avs.writedata[4*NUM_DIGITS-1:0];
                ADDR_DPMASK:   dpmask   <= avs.writedata[NUM_DIGITS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        wrap       = 1'b0;
        case (state)
            ST_IDLE: if (enable) next_state = ST_ON;
            ST_ON: begin
                if (!enable) next_state = ST_IDLE;
                else if (cnt == '0) next_state = ST_BLANK;
            end
            ST_BLANK: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (cnt == '0) begin
                    next_state = ST_ON;
                    wrap       = (digit_idx == 3'(NUM_DIGITS - 1));
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // One down-counter times both ON (PRESCALE+1) and BLANK phases; reloads
    // sample PRESCALE only here, so a mid-ON write waits for the next digit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            digit_idx <= '0;
            scan_cnt  <= '0;
            scan_of   <= 1'b0;
        end else begin
            state   <= next_state;
            scan_of <= wrap;
            if (state == ST_IDLE || next_state == ST_IDLE) begin
                cnt       <= CNT_W'(prescale);
                digit_idx <= '0;
            end else if (state == ST_ON && next_state == ST_BLANK) begin
                cnt <= CNT_W'(BLANK_CYCLES - 1);
            end else if (state == ST_BLANK && next_state == ST_ON) begin
                cnt       <= CNT_W'(prescale);
                digit_idx <= wrap ? '0 : digit_idx + 3'd1;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
            if (status_wr) scan_cnt <= '0;
            else if (wrap) scan_cnt <= scan_cnt + 16'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            ADDR_CTRL:     rd_mux[1:0]              = ctrl;
            ADDR_PRESCALE: rd_mux[PRESCALE_W-1:0]   = prescale;
            ADDR_DIGITS:   rd_mux[4*NUM_DIGITS-1:0] = digits;
            ADDR_DPMASK:   rd_mux[NUM_DIGITS-1:0]   = dpmask;
            ADDR_STATUS:   rd_mux = {scan_cnt, 11'b0, state, digit_idx};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= rd_mux;
    end

    assign avs.readdata = readdata_q;

    assign sel_oh         = NUM_DIGITS'(1) << digit_idx;
    assign digits_shifted = digits >> {digit_idx, 2'b00};
    assign lit            = (state == ST_ON) && !ctrl[CTRL_BLANK_ALL];

    controller_sseg_hex_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex (
        .value (digits_shifted[3:0]),
        .seg   (seg_dec)
    );

    always_comb begin
        seg = {7{SEG_ACTIVE_LOW}};
        dp  = SEG_ACTIVE_LOW;
        an  = {NUM_DIGITS{SEG_ACTIVE_LOW}};
        if (lit) begin
            seg = seg_dec;
            dp  = (|(dpmask & sel_oh)) ^ SEG_ACTIVE_LOW;
            an  = sel_oh ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_controller_sseg_scan.sv
// Scoreboard bench: stimulus schedules expected values per clock; a negedge
// monitor pops and compares them against the display and read bus.
module tb_controller_sseg_scan;
    import controller_sseg_scan_pkg::*;

    typedef enum {S_RD, S_AN, S_SEG, S_DP, S_OF} sig_t;
    typedef struct {
        int unsigned cyc;
        sig_t        sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       scan_of;

    int unsigned cyc = 0;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    exp_t        mon_it;
    logic [31:0] mon_got;

    controller_sseg_scan_if bus();

    controller_sseg_scan #(
        .NUM_DIGITS(4), .PRESCALE_W(16), .BLANK_CYCLES(8), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avs(bus),
        .seg(seg), .dp(dp), .an(an), .scan_of(scan_of)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int unsigned c, input sig_t s, input logic [31:0] e, input string n);
        exp_t it;
        int unsigned i = 0;
        it.cyc = c; it.sig = s; it.exp = e; it.name = n;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, it);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_it = sb.pop_front();
            case (mon_it.sig)
                S_RD:    mon_got = bus.readdata;
                S_AN:    mon_got = 32'(an);
                S_SEG:   mon_got = 32'(seg);
                S_DP:    mon_got = 32'(dp);
                default: mon_got = 32'(scan_of);
            endcase
            checks++;
            if (mon_it.cyc != cyc || mon_got !== mon_it.exp) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %h expected %h", mon_it.name, cyc, mon_got, mon_it.exp);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        bus.address = a;
        expect_at(cyc + 1, S_RD, e, n);
        @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_reset_values(input int unsigned c, input string n);
        expect_at(c, S_AN,  32'hF,  {n, "_an"});
        expect_at(c, S_SEG, 32'h7F, {n, "_seg"});
        expect_at(c, S_DP,  32'h1,  {n, "_dp"});
        expect_at(c, S_OF,  32'h0,  {n, "_of"});
        expect_at(c, S_RD,  32'h0,  {n, "_rd"});
    endtask

    initial begin
        int unsigned p;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

        expect_reset_values(2, "rst");
        wait_until(3);
        reset_n = 1'b1;
        expect_at(8, S_AN, 32'hF, "idle_an");
        rd(ADDR_STATUS, 32'h0, "idle_status");

        wr(ADDR_DIGITS, 32'hFFFF_1234);
        rd(ADDR_DIGITS, 32'h0000_1234, "digits_rb");
        wr(ADDR_PRESCALE, 32'hABCD_0003);
        rd(ADDR_PRESCALE, 32'h0000_0003, "prescale_rb");
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, 32'h0, "addr5_rd");

        // Normal scan, PRESCALE=3: 12 clks per digit, 48 per scan
        wr(ADDR_CTRL, 32'h1);
        p = cyc;
        expect_at(p,      S_AN,  32'hF,  "scan_idle_an");
        expect_at(p + 1,  S_AN,  32'hE,  "scan_d0_an");
        expect_at(p + 1,  S_SEG, 32'h19, "scan_d0_seg");
        expect_at(p + 1,  S_DP,  32'h1,  "scan_d0_dp");
        expect_at(p + 1,  S_OF,  32'h0,  "scan_start_of");
        expect_at(p + 4,  S_AN,  32'hE,  "scan_d0_last_an");
        expect_at(p + 5,  S_AN,  32'hF,  "scan_blank0_an");
        expect_at(p + 12, S_AN,  32'hF,  "scan_blank0_end_an");
        expect_at(p + 13, S_AN,  32'hD,  "scan_d1_an");
        expect_at(p + 13, S_SEG, 32'h30, "scan_d1_seg");
        expect_at(p + 25, S_AN,  32'hB,  "scan_d2_an");
        expect_at(p + 25, S_SEG, 32'h24, "scan_d2_seg");
        expect_at(p + 37, S_AN,  32'h7,  "scan_d3_an");
        expect_at(p + 37, S_SEG, 32'h79, "scan_d3_seg");
        expect_at(p + 48, S_OF,  32'h0,  "scan_pre_wrap_of");
        expect_at(p + 49, S_OF,  32'h1,  "scan_wrap1_of");
        expect_at(p + 49, S_AN,  32'hE,  "scan_wrap1_an");
        expect_at(p + 50, S_OF,  32'h0,  "scan_post_wrap_of");
        expect_at(p + 97, S_OF,  32'h1,  "scan_wrap2_of");
        rd(ADDR_CTRL, 32'h1, "ctrl_rb");
        wait_until(p + 98);

        // Disable mid-ON, then re-enable
        wr(ADDR_CTRL, 32'h0);
        p = cyc;
        expect_at(p + 1, S_AN, 32'hF, "dis_an");
        rd(ADDR_STATUS, 32'h0002_0000, "dis_status");
        wr(ADDR_CTRL, 32'h1);
        p = cyc;
        expect_at(p + 1,  S_AN, 32'hE, "reen_d0_an");
        expect_at(p + 1,  S_OF, 32'h0, "reen_no_of");
        expect_at(p + 13, S_AN, 32'hD, "reen_d1_an");
        expect_at(p + 49, S_OF, 32'h1, "clrwrap_of");
        wait_until(p + 47);
        wr(ADDR_STATUS, 32'h0);
        rd(ADDR_STATUS, 32'h0000_0008, "clrwrap_status");

        // PRESCALE=0: 9 clks per digit, 36 per scan
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_PRESCALE, 32'h0);
        wr(ADDR_STATUS, 32'h0);
        wr(ADDR_CTRL, 32'h1);
        p = cyc;
        expect_at(p + 1,   S_AN, 32'hE, "ps0_d0_an");
        expect_at(p + 2,   S_AN, 32'hF, "ps0_blank_an");
        expect_at(p + 10,  S_AN, 32'hD, "ps0_d1_an");
        expect_at(p + 19,  S_AN, 32'hB, "ps0_d2_an");
        expect_at(p + 28,  S_AN, 32'h7, "ps0_d3_an");
        expect_at(p + 36,  S_OF, 32'h0, "ps0_pre_wrap_of");
        expect_at(p + 37,  S_OF, 32'h1, "ps0_wrap1_of");
        expect_at(p + 38,  S_OF, 32'h0, "ps0_post_wrap_of");
        expect_at(p + 73,  S_OF, 32'h1, "ps0_wrap2_of");
        expect_at(p + 109, S_OF, 32'h1, "ps0_wrap3_of");
        wait_until(p + 110);
        rd(ADDR_STATUS, 32'h0003_0010, "ps0_status");

        // blank_all: anodes dark, scan_of keeps 48-clk period
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_PRESCALE, 32'h3);
        wr(ADDR_DPMASK, 32'h2);
        wr(ADDR_CTRL, 32'h3);
        p = cyc;
        expect_at(p + 1,  S_AN,  32'hF,  "blk_d0_an");
        expect_at(p + 1,  S_SEG, 32'h7F, "blk_d0_seg");
        expect_at(p + 13, S_AN,  32'hF,  "blk_d1_an");
        expect_at(p + 13, S_DP,  32'h1,  "blk_d1_dp");
        expect_at(p + 48, S_OF,  32'h0,  "blk_pre_wrap_of");
        expect_at(p + 49, S_OF,  32'h1,  "blk_wrap1_of");
        expect_at(p + 97, S_OF,  32'h1,  "blk_wrap2_of");
        wait_until(p + 98);

        // DPMASK=2 visible only on digit 1; DIGITS write lands the next clk
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_CTRL, 32'h1);
        p = cyc;
        expect_at(p + 1,  S_DP,  32'h1,  "dpm_d0_dp");
        expect_at(p + 13, S_DP,  32'h0,  "dpm_d1_dp");
        expect_at(p + 13, S_AN,  32'hD,  "dpm_d1_an");
        expect_at(p + 13, S_SEG, 32'h30, "mid_old_seg");
        expect_at(p + 14, S_SEG, 32'h0E, "mid_new_seg");
        expect_at(p + 16, S_AN,  32'hF,  "midrst_an");
        expect_at(p + 16, S_SEG, 32'h7F, "midrst_seg");
        expect_at(p + 16, S_DP,  32'h1,  "midrst_dp");
        expect_at(p + 16, S_OF,  32'h0,  "midrst_of");
        wait_until(p + 12);
        wr(ADDR_DIGITS, 32'h0000_12F4);
        wait_until(p + 15);
        #1 reset_n = 1'b0;
        wait_until(p + 18);
        reset_n = 1'b1;
        expect_at(p + 24, S_AN, 32'hF, "post_rst_an");
        rd(ADDR_CTRL, 32'h0, "post_rst_ctrl");
        rd(ADDR_DIGITS, 32'h0, "post_rst_digits");
        rd(ADDR_STATUS, 32'h0, "post_rst_status");

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unsampled expectations, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
